// File: rtl/audio_sample_ram_writer_if.sv
// Write-side slave bus of the on-chip RAM as driven by the sample writer.
// The master drives the request; the RAM arbiter returns grant.
interface audio_sample_ram_writer_if #(
  parameter int ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0] address;
  logic [3:0]            byteenable;
  logic                  chipselect;
  logic                  write;
  logic [31:0]           writedata;
  logic                  clken;
  logic                  grant;

  modport master (
    output address,
    output byteenable,
    output chipselect,
    output write,
    output writedata,
    output clken,
    input  grant
  );

  modport slave (
    input  address,
    input  byteenable,
    input  chipselect,
    input  write,
    input  writedata,
    input  clken,
    output grant
  );
endinterface

// File: rtl/audio_sample_ram_writer.sv
// Packs 16-bit sample pairs into a RAM ring and pulses at half/full marks.
// Optional per-half |sample| peak output: define AUDIO_WRITER_PEAK_EN.
module audio_sample_ram_writer #(
  parameter int ADDR_WIDTH = 15,
  parameter int BASE_ADDR  = 0,
  parameter int BUF_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [15:0]           s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  audio_sample_ram_writer_if.master ram,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic                  irq_half,
  output logic                  irq_full,
  output logic                  overflow,
  input  logic                  clr_overflow
`ifdef AUDIO_WRITER_PEAK_EN
  ,output logic [15:0]          peak
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    PEND
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] P_LAST = ADDR_WIDTH'(BUF_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] P_HALF = ADDR_WIDTH'(BUF_WORDS / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] P_BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] P_ONE  = ADDR_WIDTH'(1);

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_lo;
  logic [31:0]           r_wdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic                  r_irq_half;
  logic                  r_irq_full;
  logic                  r_ovf;

  logic w_ready;
  logic w_load_lo;
  logic w_issue;
  logic w_done;
  logic w_ovf_set;
  logic w_at_half;
  logic w_at_full;

  always_comb begin
    w_next    = r_state;
    w_ready   = 1'b0;
    w_load_lo = 1'b0;
    w_issue   = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable) w_next = LO;
      end
      LO: begin
        w_ready = 1'b1;
        if (s_valid) begin
          w_load_lo = 1'b1;
          w_next    = HI;
        end else if (!enable) begin
          w_next = IDLE;
        end
      end
      HI: begin
        w_ready = 1'b1;
        if (s_valid) begin
          w_issue = 1'b1;
          w_next  = PEND;
        end else if (!enable) begin
          w_next = IDLE;
        end
      end
      PEND: begin
        // The pending word always completes, even if capture was disabled.
        if (ram.grant) begin
          w_done = 1'b1;
          w_next = enable ? LO : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_ovf_set = s_valid & ~w_ready & (r_state != IDLE);
  assign w_at_half = w_done & (r_wr_ptr == P_HALF);
  assign w_at_full = w_done & (r_wr_ptr == P_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_lo       <= '0;
      r_wdata    <= '0;
      r_addr     <= P_BASE;
      r_write    <= 1'b0;
      r_wr_ptr   <= '0;
      r_irq_half <= 1'b0;
      r_irq_full <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load_lo) r_lo <= s_data;
      if (w_issue) begin
        r_wdata <= {s_data, r_lo};
        r_addr  <= P_BASE + r_wr_ptr;
        r_write <= 1'b1;
      end else if (w_done) begin
        r_write <= 1'b0;
      end
      if (w_done)
        r_wr_ptr <= (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + P_ONE;
      r_irq_half <= w_at_half;
      r_irq_full <= w_at_full;
      if (w_ovf_set)         r_ovf <= 1'b1;
      else if (clr_overflow) r_ovf <= 1'b0;
    end
  end

  assign s_ready        = w_ready;
  assign ram.address    = r_addr;
  assign ram.writedata  = r_wdata;
  assign ram.write      = r_write;
  assign ram.chipselect = r_write;
  assign ram.byteenable = {4{r_write}};
  assign ram.clken      = 1'b1;
  assign wr_ptr         = r_wr_ptr;
  assign irq_half       = r_irq_half;
  assign irq_full       = r_irq_full;
  assign overflow       = r_ovf;

`ifdef AUDIO_WRITER_PEAK_EN
  logic        w_accept;
  logic [15:0] w_abs;
  logic [15:0] r_run;
  logic [15:0] r_peak;

  assign w_accept = s_valid & w_ready;
  // Magnitude of -32768 saturates so the peak fits in 15 bits.
  assign w_abs = (s_data == 16'h8000) ? 16'h7FFF :
                 s_data[15] ? (16'h0000 - s_data) : s_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_run  <= '0;
      r_peak <= '0;
    end else if (w_at_half | w_at_full) begin
      r_peak <= r_run;
      r_run  <= w_accept ? w_abs : 16'h0000;
    end else if (w_accept && (w_abs > r_run)) begin
      r_run <= w_abs;
    end
  end

  assign peak = r_peak;
`endif

endmodule

// File: tb/tb_audio_sample_ram_writer.sv
// Scoreboard bench for audio_sample_ram_writer on a 4-word ring.
// Stimulus queues expected writes/irqs; a negedge monitor checks them.
module tb_audio_sample_ram_writer;
  localparam int AW   = 15;
  localparam int BASE = 8;
  localparam int BW   = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [15:0]   s_data = 16'h0000;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [AW-1:0] wr_ptr;
  logic          irq_half;
  logic          irq_full;
  logic          overflow;
  logic          clr_overflow = 1'b0;
`ifdef AUDIO_WRITER_PEAK_EN
  logic [15:0]   peak;
`endif

  audio_sample_ram_writer_if #(.ADDR_WIDTH(AW)) ram ();

  audio_sample_ram_writer #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (BASE),
    .BUF_WORDS (BW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .ram         (ram),
    .wr_ptr      (wr_ptr),
    .irq_half    (irq_half),
    .irq_full    (irq_full),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
`ifdef AUDIO_WRITER_PEAK_EN
    ,.peak       (peak)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    bit          full;
    logic [15:0] pk;
  } irq_t;

  wr_t  wq[$];
  irq_t iq[$];
  wr_t  mw;
  irq_t mi;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ptr = 0;
  int exp_run = 0;

  logic [31:0] mem     [0:63];
  logic [31:0] exp_mem [0:BW-1];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int absv(input logic [15:0] d);
    int x;
    x = int'($signed(d));
    if (x < 0) x = -x;
    if (x > 32767) x = 32767;
    return x;
  endfunction

  always @(posedge clk)
    if (ram.write && ram.grant) mem[ram.address[5:0]] <= ram.writedata;

  always @(negedge clk) begin
    if (reset_n) begin
      if (ram.write && ram.grant) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 32'(ram.address), 32'hFFFF_FFFF);
        end else begin
          mw = wq.pop_front();
          chk("address", 32'(ram.address), 32'(mw.addr));
          chk("writedata", ram.writedata, mw.data);
          chk("byteenable", 32'(ram.byteenable), 32'hF);
          chk("chipselect", 32'(ram.chipselect), 32'd1);
        end
      end
      if (irq_half || irq_full) begin
        if (iq.size() == 0) begin
          chk("unexpected_irq", {30'd0, irq_full, irq_half}, 32'd0);
        end else begin
          mi = iq.pop_front();
          chk("irq_half", 32'(irq_half), 32'(!mi.full));
          chk("irq_full", 32'(irq_full), 32'(mi.full));
`ifdef AUDIO_WRITER_PEAK_EN
          chk("peak", 32'(peak), 32'(mi.pk));
`endif
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    chk("s_ready_wait", 32'(s_ready), 32'd1);
    s_data  = d;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    if (absv(d) > exp_run) exp_run = absv(d);
  endtask

  task automatic pair(input logic [15:0] lo, input logic [15:0] hi);
    send(lo);
    send(hi);
    wq.push_back('{addr: AW'(BASE + exp_ptr), data: {hi, lo}});
    exp_mem[exp_ptr] = {hi, lo};
    if (exp_ptr == 1 || exp_ptr == BW - 1) begin
      iq.push_back('{full: (exp_ptr == BW - 1), pk: 16'(exp_run)});
      exp_run = 0;
    end
    exp_ptr = (exp_ptr + 1) % BW;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (ram.write && n < 50) begin
      tick();
      n++;
    end
    chk("write_drain", 32'(ram.write), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    for (int i = 0; i < BW; i++) exp_mem[i] = 32'h0;
    ram.grant = 1'b0;

    repeat (3) tick();
    chk("rst_write", 32'(ram.write), 32'd0);
    chk("rst_cs", 32'(ram.chipselect), 32'd0);
    chk("rst_wdata", ram.writedata, 32'd0);
    chk("rst_addr", 32'(ram.address), 32'(BASE));
    chk("rst_be", 32'(ram.byteenable), 32'd0);
    chk("rst_clken", 32'(ram.clken), 32'd1);
    chk("rst_irq", {30'd0, irq_full, irq_half}, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);

    reset_n   = 1'b1;
    enable    = 1'b1;
    ram.grant = 1'b1;
    tick();
    pair(16'h1111, 16'h2222);
    drain();
    chk("ptr_after_first", 32'(wr_ptr), 32'd1);

    ram.grant = 1'b0;
    pair(16'h3333, 16'h4444);
    for (int i = 0; i < 5; i++) begin
      chk("hold_write", 32'(ram.write), 32'd1);
      chk("hold_addr", 32'(ram.address), 32'(BASE + 1));
      chk("hold_data", ram.writedata, 32'h4444_3333);
      chk("hold_ready", 32'(s_ready), 32'd0);
      tick();
    end
    s_data  = 16'h7777;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    ram.grant = 1'b1;
    drain();
    chk("ptr_after_hold", 32'(wr_ptr), 32'd2);

    pair(16'hA001, 16'h0002);
    pair(16'h0003, 16'h0004);
    drain();
    chk("ptr_wrap", 32'(wr_ptr), 32'd0);
    pair(16'h0005, 16'h0006);
    pair(16'h0007, 16'h0008);
    drain();
    chk("ptr_after_wrap", 32'(wr_ptr), 32'd2);

    send(16'h5555);
    enable = 1'b0;
    tick();
    chk("drop_ready", 32'(s_ready), 32'd0);
    repeat (3) tick();
    chk("drop_no_write", 32'(ram.write), 32'd0);
    chk("drop_ptr", 32'(wr_ptr), 32'd2);
    enable = 1'b1;
    pair(16'h6666, 16'h7777);
    drain();
    chk("ptr_after_drop", 32'(wr_ptr), 32'd3);

    ram.grant = 1'b0;
    send(16'h8888);
    send(16'h9999);
    chk("pend_write", 32'(ram.write), 32'd1);
    enable  = 1'b0;
    reset_n = 1'b0;
    tick();
    chk("mid_rst_write", 32'(ram.write), 32'd0);
    chk("mid_rst_cs", 32'(ram.chipselect), 32'd0);
    chk("mid_rst_addr", 32'(ram.address), 32'(BASE));
    chk("mid_rst_wdata", ram.writedata, 32'd0);
    chk("mid_rst_be", 32'(ram.byteenable), 32'd0);
    chk("mid_rst_ptr", 32'(wr_ptr), 32'd0);
    chk("mid_rst_irq", {30'd0, irq_full, irq_half}, 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    reset_n   = 1'b1;
    ram.grant = 1'b1;
    exp_ptr   = 0;
    exp_run   = 0;
    repeat (3) tick();
    chk("mem_idx3_kept", mem[BASE + 3], exp_mem[3]);
    chk("mem_idx2_kept", mem[BASE + 2], exp_mem[2]);

    enable = 1'b1;
    tick();
    pair(16'd100, 16'hFED4);
    pair(16'h8000, 16'd5);
    pair(16'd1, 16'd2);
    pair(16'd3, 16'd4);
    drain();
    chk("ptr_final", 32'(wr_ptr), 32'd0);

    for (int i = 0; i < 50 && (wq.size() != 0 || iq.size() != 0); i++)
      tick();
    chk("writes_left", 32'(wq.size()), 32'd0);
    chk("irqs_left", 32'(iq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/audio_sample_ram_writer.md
Name: audio_sample_ram_writer

Overview:
- Stream-to-memory writer directly upstream of the NIOS on-chip RAM; owns that RAM's write-side slave signals.
- Accepts signed 16-bit audio samples and packs pairs into 32-bit words (first sample in [15:0]).
- Writes the packed words into a circular region of the RAM and raises half- and full-buffer pulses, so firmware can process one half while the other fills.

Parameters:
- ADDR_WIDTH, 15, word-address width; matches the RAM.
- BASE_ADDR, 0, first word address of the ring.
- BUF_WORDS, 1024, ring length in 32-bit words; even, >= 2, BASE_ADDR+BUF_WORDS <= 25000.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- enable  in  1  capture enable from control logic.
- s_data  in  16  signed audio sample.
- s_valid  in  1  sample present this cycle.
- s_ready  out  1  writer can accept a sample this cycle.
- grant  in  1  RAM write slot granted; write accepted in any cycle where write=1 and grant=1.
- address  out  ADDR_WIDTH  RAM word address.
- byteenable  out  4  always 4'hF while write=1; 4'h0 otherwise.
- chipselect  out  1  equals write.
- write  out  1  write request.
- writedata  out  32  packed sample pair.
- clken  out  1  constant 1.
- wr_ptr  out  ADDR_WIDTH  ring index of the next word to write.
- irq_half  out  1  one-cycle pulse.
- irq_full  out  1  one-cycle pulse.
- overflow  out  1  sticky sample-drop flag.
- clr_overflow  in  1  clears overflow.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE; wr_ptr=0; write/chipselect=0; writedata=0; address=BASE_ADDR; byteenable=0; irq_half/irq_full=0; overflow=0. clken stays 1.
- States: IDLE, LO, HI, PEND.
- IDLE:
  - s_ready=0.
  - enable=1 -> LO; wr_ptr is not cleared, so the ring resumes where it stopped.
- LO:
  - s_ready=1.
  - s_valid=1 -> latch s_data into lo register; -> HI.
  - enable=0 -> IDLE.
- HI:
  - s_ready=1.
  - s_valid=1 -> writedata={s_data, lo}; address=BASE_ADDR+wr_ptr; write=1; -> PEND. All of these are registered, so they are valid the cycle after the accept.
  - enable=0 -> IDLE; the partial sample is discarded.
- PEND:
  - s_ready=0; write=1 held and stable.
  - grant=1 -> write=0 next cycle; wr_ptr = (wr_ptr==BUF_WORDS-1) ? 0 : wr_ptr+1.
  - After a grant: enable=1 -> LO; enable=0 -> IDLE.
  - enable=0 while waiting for grant: the pending write still completes before leaving PEND.
- Samples are accepted only when s_valid & s_ready. Maximum throughput is 2 samples per 3 cycles with continuous grant.
- overflow:
  - Set when s_valid=1, s_ready=0 and state!=IDLE; the source cannot stall, so that sample is lost.
  - clr_overflow=1 clears it; a set in the same cycle wins.
- irq_half: asserted for exactly the one cycle after the granted write at ring index BUF_WORDS/2-1.
- irq_full: asserted for exactly the one cycle after the granted write at ring index BUF_WORDS-1; the wrap to 0 happens on the same edge.
- Synchronous reset mid-PEND abandons the write; the RAM is not written, because write is cleared on that edge.

Optional Feature:
- Macro: AUDIO_WRITER_PEAK_EN.
- Defined:
  - Adds output peak[15:0], the unsigned maximum |sample| over each half-buffer.
  - |-32768| saturates to 32767.
  - The running maximum is updated on every accepted sample, including the discarded partial.
  - peak is loaded with the running maximum on the cycle irq_half or irq_full asserts; the running maximum restarts from the sample accepted on that same cycle, else 0.
  - Reset value 0.
- Undefined: no peak port and no peak logic; all other behaviour is identical.

Test Plan:
- Reset, enable=1, grant=1, samples 16'h1111 then 16'h2222 -> one write cycle with address=BASE_ADDR, writedata=32'h2222_1111, byteenable=4'hF; then wr_ptr=1.
- grant=0 for 5 cycles during PEND -> write, address and writedata held stable for 5 cycles and s_ready=0; a sample offered then sets overflow=1; clr_overflow=1 -> overflow=0.
- BUF_WORDS=4, 8 samples with continuous grant -> irq_half after index 1, irq_full after index 3, wr_ptr returns to 0, and the 5th word is written at BASE_ADDR.
- enable dropped in HI after one sample -> IDLE, no write issued; on re-enable the next pair lands at the unchanged wr_ptr.
- reset_n=0 during PEND -> write=0 on the next cycle, all outputs at reset values, and the RAM contents are unchanged.
- With AUDIO_WRITER_PEAK_EN, BUF_WORDS=4: samples 100, -300, 16'h8000, 5 -> peak=32767 at irq_half; the next half with samples 1, 2, 3, 4 -> peak=4.
